// File: rtl/cnt_timer_regs.sv
// rtl/cnt_timer_regs.sv - W-bit up-counter with CONTROL/THRESHOLD/VALUE/STATUS registers on an OBI-style slave port
// Optional CNT_TIMER_IRQ_MASK_EN adds CONTROL.IE (bit2) gating tc_int_o.
module cnt_timer_regs #(
    parameter int W = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        tc_int_o
);

    generate
        if (W < 1 || W > 32) begin : g_bad_w
            $fatal(1, "cnt_timer_regs: W must be in 1..32");
        end
    endgenerate

    logic [W-1:0] r_cnt;
    logic [W-1:0] r_thr;
    logic         r_en;
    logic         r_clr;
    logic         r_tc_stat;
    logic         r_tc_int;
    logic         r_rvalid;
    logic [31:0]  r_rdata;

    logic         w_wr;
    logic         w_rd;
    logic [1:0]   w_off;
    logic         w_ctrl_wr;
    logic         w_stat_w1c;
    logic         w_tc_event;
    logic         w_ie_rd;
    logic         w_irq_gate;
    logic [W-1:0] w_thr_wr;
    logic [31:0]  w_thr_ext;
    logic [31:0]  w_cnt_ext;
    logic [31:0]  w_rdata_nxt;
    logic         w_unused_bits;

    assign gnt_o         = req_i;
    assign w_wr          = req_i & we_i;
    assign w_rd          = req_i & ~we_i;
    assign w_off         = addr_i[3:2];
    assign w_ctrl_wr     = w_wr && (w_off == 2'd0) && be_i[0];
    assign w_stat_w1c    = w_wr && (w_off == 2'd3) && be_i[0] && wdata_i[0];
    assign w_unused_bits = ^{addr_i[31:4], addr_i[1:0], wdata_i};

    // A pending clear pulse suppresses the terminal-count compare.
    assign w_tc_event = r_en && !r_clr && (r_cnt == r_thr);

`ifdef CNT_TIMER_IRQ_MASK_EN
    logic r_ie;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ie <= 1'b0;
        end else if (w_ctrl_wr) begin
            r_ie <= wdata_i[2];
        end
    end
    assign w_ie_rd    = r_ie;
    assign w_irq_gate = r_ie;
`else
    assign w_ie_rd    = 1'b0;
    assign w_irq_gate = 1'b1;
`endif

    always_comb begin
        w_thr_wr = r_thr;
        for (int i = 0; i < W; i++) begin
            w_thr_wr[i] = be_i[i/8] ? wdata_i[i] : r_thr[i];
        end
    end

    always_comb begin
        w_thr_ext = '0;
        w_cnt_ext = '0;
        w_thr_ext[W-1:0] = r_thr;
        w_cnt_ext[W-1:0] = r_cnt;
    end

    always_comb begin
        w_rdata_nxt = '0;
        case (w_off)
            2'd0:    w_rdata_nxt = {29'd0, w_ie_rd, 1'b0, r_en};
            2'd1:    w_rdata_nxt = w_thr_ext;
            2'd2:    w_rdata_nxt = w_cnt_ext;
            default: w_rdata_nxt = {31'd0, r_tc_stat};
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_en  <= 1'b0;
            r_clr <= 1'b0;
            r_thr <= '0;
        end else begin
            r_clr <= w_ctrl_wr && wdata_i[1];
            if (w_ctrl_wr) begin
                r_en <= wdata_i[0];
            end
            if (w_wr && (w_off == 2'd1)) begin
                r_thr <= w_thr_wr;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (r_clr || w_tc_event) begin
            r_cnt <= '0;
        end else if (r_en) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    // Set beats W1C when both land on the same edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_tc_stat <= 1'b0;
            r_tc_int  <= 1'b0;
        end else begin
            r_tc_int <= w_tc_event && w_irq_gate;
            if (w_tc_event) begin
                r_tc_stat <= 1'b1;
            end else if (w_stat_w1c) begin
                r_tc_stat <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= req_i;
            r_rdata  <= w_rd ? w_rdata_nxt : 32'd0;
        end
    end

    assign rvalid_o = r_rvalid;
    assign rdata_o  = r_rdata;
    assign tc_int_o = r_tc_int;

endmodule

// File: tb/tb_cnt_timer_regs.sv
// tb/tb_cnt_timer_regs.sv - directed scoreboard bench for cnt_timer_regs (W=4)
module tb_cnt_timer_regs;

    localparam int W = 4;
`ifdef CNT_TIMER_IRQ_MASK_EN
    localparam logic HAS_IE = 1'b1;
`else
    localparam logic HAS_IE = 1'b0;
`endif

    logic        clk_i;
    logic        rst_i;
    logic        req_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        gnt_o;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        tc_int_o;

    typedef struct {
        logic        v;
        logic [31:0] d;
    } sb_t;

    sb_t sb[$];
    int  n_assert = 0;
    int  n_fail   = 0;
    int  n_step   = 0;

    cnt_timer_regs #(.W(W)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req_i    (req_i),
        .we_i     (we_i),
        .be_i     (be_i),
        .addr_i   (addr_i),
        .wdata_i  (wdata_i),
        .gnt_o    (gnt_o),
        .rvalid_o (rvalid_o),
        .rdata_o  (rdata_o),
        .tc_int_o (tc_int_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s step %0d: observed %h expected %h", tag, n_step, got, exp);
        end
    endtask

    // Checks the response of the previous cycle's request, then drives this cycle's request.
    task automatic step(input logic req, input logic we, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] be,
                        input logic [31:0] exp, input logic exp_tc);
        sb_t e;
        @(negedge clk_i);
        n_step++;
        e = sb.pop_front();
        chk("rvalid", {31'd0, rvalid_o}, {31'd0, e.v});
        chk("rdata", rdata_o, e.d);
        chk("tc_int", {31'd0, tc_int_o}, {31'd0, exp_tc});
        req_i   = req;
        we_i    = we;
        addr_i  = addr;
        wdata_i = data;
        be_i    = be;
        #1;
        chk("gnt", {31'd0, gnt_o}, {31'd0, req});
        sb.push_back('{req, (req && !we) ? exp : 32'd0});
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input logic tc);
        step(1'b1, 1'b0, addr, 32'd0, 4'hF, exp, tc);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be, input logic tc);
        step(1'b1, 1'b1, addr, data, be, 32'd0, tc);
    endtask

    task automatic idle(input logic tc);
        step(1'b0, 1'b0, 32'd0, 32'd0, 4'h0, 32'd0, tc);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        req_i = 1'b0;
        @(negedge clk_i);
        chk("rst_rvalid", {31'd0, rvalid_o}, 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_tc_int", {31'd0, tc_int_o}, 32'd0);
        rst_i = 1'b0;
        sb.delete();
        sb.push_back('{1'b0, 32'd0});
    endtask

    initial begin
        logic gate0;
        gate0   = !HAS_IE;
        rst_i   = 1'b1;
        req_i   = 1'b0;
        we_i    = 1'b0;
        be_i    = 4'h0;
        addr_i  = 32'd0;
        wdata_i = 32'd0;

        do_reset();
        rd(32'h0, 0, 0); rd(32'h4, 0, 0); rd(32'h8, 0, 0); rd(32'hC, 0, 0);

        // Count 0..5 then terminal count
        wr(32'h4, 5, 4'hF, 0);
        wr(32'h0, 1, 4'hF, 0);
        for (int v = 0; v <= 5; v++) rd(32'h8, v, 0);
        rd(32'h8, 0, 1);
        rd(32'hC, 1, 0);
        wr(32'hC, 1, 4'hF, 0);
        rd(32'hC, 0, 0);
        wr(32'h0, 2, 4'b0010, 0);
        rd(32'h8, 5, 0);
        rd(32'h0, 1, 1);
        rd(32'hC, 1, 0);
        wr(32'hC, 1, 4'hF, 0);

        // Clear while running at count 3
        wr(32'h0, 3, 4'hF, 0);
        rd(32'h8, 4, 0);
        rd(32'h8, 0, 0);
        rd(32'h8, 1, 0);
        rd(32'h0, 1, 0);
        rd(32'hC, 0, 0);
        wr(32'h0, 0, 4'hF, 0);
        rd(32'h8, 5, 0);
        idle(0);
        rd(32'h8, 5, 0);

        // Threshold lowered below count: wrap through 15 without tc
        wr(32'h4, 2, 4'hF, 0);
        wr(32'h0, 1, 4'hF, 0);
        for (int v = 5; v <= 15; v++) rd(32'h8, v, 0);
        rd(32'h8, 0, 0);
        rd(32'h8, 1, 0);
        rd(32'h8, 2, 0);
        rd(32'h8, 0, 1);
        rd(32'h4, 2, 0);
        wr(32'h0, 0, 4'hF, 0);
        idle(1);
        rd(32'h8, 0, 0);
        rd(32'hC, 1, 0);

        // Byte enables and zero-extension on THRESHOLD
        wr(32'h4, 7, 4'hF, 0);
        wr(32'h4, 32'h0000_0100, 4'b0010, 0);
        rd(32'h4, 7, 0);
        wr(32'h4, 32'hFFFF_FFF3, 4'b0001, 0);
        rd(32'h4, 3, 0);

        // Threshold 0: tc every cycle
        wr(32'h4, 0, 4'hF, 0);
        wr(32'h0, 1, 4'hF, 0);
        rd(32'h8, 0, 0);
        rd(32'h8, 0, 1); rd(32'h8, 0, 1); rd(32'h8, 0, 1);
        wr(32'h0, 0, 4'hF, 1);
        idle(1);
        idle(0);
        rd(32'h8, 0, 0);

        // Interrupt mask
        wr(32'hC, 1, 4'hF, 0);
        wr(32'h4, 1, 4'hF, 0);
        wr(32'h0, 1, 4'hF, 0);
        rd(32'hC, 0, 0);
        idle(0);
        idle(gate0);
        rd(32'hC, 1, 0);
        wr(32'h0, 5, 4'hF, gate0);
        rd(32'h0, HAS_IE ? 32'd5 : 32'd1, 0);
        idle(1);
        idle(0);
        idle(1);
        idle(0);

        // Reset mid-run clears everything
        do_reset();
        rd(32'h0, 0, 0); rd(32'h4, 0, 0); rd(32'h8, 0, 0); rd(32'hC, 0, 0);
        idle(0);
        idle(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/cnt_timer_regs.md
Name: cnt_timer_regs

Overview:
- Memory-mapped up-counter peripheral: a W-bit counter plus its control/status register file, behind a simple OBI-style slave port.
- Host software enables and clears the counter, sets a terminal-count threshold, reads the live value, and receives an interrupt when the threshold is reached.
- Sits on the system peripheral bus; `tc_int_o` routes to the host interrupt controller.

Parameters:
- W, 32, counter bit width; legal range 1..32.

Ports:
- clk_i  in  1  single clock, all logic rising-edge.
- rst_i  in  1  reset, synchronous, active-high.
- req_i  in  1  bus request.
- we_i  in  1  1 = write, 0 = read.
- be_i  in  4  byte enables for writes.
- addr_i  in  32  byte address; only addr_i[3:2] decoded.
- wdata_i  in  32  write data.
- gnt_o  out  1  grant.
- rvalid_o  out  1  response valid.
- rdata_o  out  32  read data.
- tc_int_o  out  1  terminal-count interrupt pulse.

Behaviour:
- Reset (rst_i=1 at a clock edge) forces the following to 0: counter, CONTROL, THRESHOLD, STATUS, rvalid_o, rdata_o, tc_int_o. gnt_o is combinational and is not reset.
- Handshake:
  - gnt_o = req_i, combinational; every request is accepted in the cycle it is presented.
  - rvalid_o pulses high exactly 1 cycle after each granted request, for reads and writes alike. Back-to-back requests give back-to-back rvalid.
  - rdata_o is registered and valid while rvalid_o=1. It is 0 for write responses and whenever rvalid_o=0.
- Register map (offset = addr_i[3:2]*4):
  - 0x0 CONTROL:
    - bit0 EN, read/write.
    - bit1 CLR, write-only self-clearing; writing 1 produces a 1-cycle clear pulse the following cycle; reads 0.
    - Other bits read 0.
  - 0x4 THRESHOLD: read/write; low W bits stored; reads zero-extended.
  - 0x8 VALUE: read-only current count, zero-extended; writes ignored.
  - 0xC STATUS: bit0 TC, sticky; set by a terminal-count event, cleared by writing 1 to bit0 (W1C).
- Byte enables: a write updates only the bytes whose be_i bit is 1. CLR and W1C act only if be_i[0]=1.
- Counter, per cycle, in priority order:
  1. clr pulse active: count <= 0; no tc event.
  2. Else if EN=1 and count == THRESHOLD: count <= 0; tc event.
  3. Else if EN=1: count <= count+1, wrapping modulo 2^W with no tc event.
  4. Else: hold.
- tc_int_o: registered, high for exactly 1 cycle, in the cycle after a tc event, i.e. the same cycle the count reads 0.
- STATUS.TC sets on the same edge that tc_int_o rises. If a tc event and a W1C write coincide, set wins.
- THRESHOLD = 0 with EN=1: tc event every cycle; count stays 0.
- THRESHOLD lowered below the current count: the counter runs up to 2^W-1, wraps to 0, then terminates at the new threshold.
- Register writes take effect at the clock edge that grants them.
- A read in the same cycle as a write to the same register returns the pre-write value.
- Simulation-only check: fatal error if W is outside 1..32.

Optional Feature:
- Macro: CNT_TIMER_IRQ_MASK_EN.
- Defined:
  - CONTROL bit2 IE is read/write, reset value 0.
  - tc_int_o = tc pulse AND IE.
  - STATUS.TC still sets regardless of IE.
- Undefined:
  - CONTROL bit2 reads 0 and ignores writes.
  - tc_int_o is the ungated tc pulse.

Test Plan:
- Reset, then read all four offsets -> each returns 0; rvalid_o is high exactly 1 cycle after each req_i; gnt_o=1 in the request cycle.
- Write THRESHOLD=5, then CONTROL=0x1 -> VALUE counts 0,1,..,5,0. tc_int_o is high for 1 cycle as count returns to 0; STATUS reads 0x1.
- Write STATUS=0x1 -> STATUS reads 0. Then with be_i=4'b0010, write CONTROL=0x2 -> no clear occurs, EN unchanged.
- Counter running at count 3, write CONTROL=0x3 -> next cycle count is 0 and no tc pulse; then counting resumes from 0; CONTROL reads 0x1.
- W=4, THRESHOLD=2, count at 7 -> counter runs 8..15, wraps to 0 with no tc_int_o; tc_int_o pulses after the next 0,1,2.
- Macro defined, IE=0, THRESHOLD=1, EN=1 -> STATUS.TC=1 and tc_int_o stays 0. Set IE=1 -> tc_int_o pulses every 2 cycles.
